// File: rtl/fb_pkg.sv
// Shared state encoding and framebuffer geometry helpers
// for the framebuffer scheduler.
package fb_pkg;

    typedef enum logic [0:0] {
        IDLE         = 1'b0,
        SWAP_PENDING = 1'b1
    } fb_state_e;

    function automatic int fb_w(input int h_active, input int scale);
        return h_active / scale;
    endfunction

    function automatic int fb_h(input int v_active, input int scale);
        return v_active / scale;
    endfunction

    function automatic int fb_addr_w(
        input int h_active,
        input int v_active,
        input int scale
    );
        return $clog2(2 * fb_w(h_active, scale) * fb_h(v_active, scale));
    endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Linear framebuffer address: buffer base plus y*FB_W+x.
// Buffer 1 sits directly above buffer 0 so both fit in 2*FB_W*FB_H words.
module fb_addr_gen #(
    parameter int FB_W   = 160,
    parameter int FB_H   = 120,
    parameter int ADDR_W = 16,
    parameter int X_W    = 8,
    parameter int Y_W    = 7
) (
    input  logic              buf_sel,
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [ADDR_W-1:0] ROW      = ADDR_W'(FB_W);
    localparam logic [ADDR_W-1:0] BUF_BASE = ADDR_W'(FB_W * FB_H);

    logic [ADDR_W-1:0] base;

    always_comb begin
        base = buf_sel ? BUF_BASE : '0;
        addr = base + ADDR_W'(y) * ROW + ADDR_W'(x);
    end

endmodule

// File: rtl/framebuffer_scheduler.sv
// Single-port framebuffer arbiter: upscaled scan-out reads every SCALE
// pixels, draw writes in all other slots, tear-free buffer swap at frame start.
module framebuffer_scheduler
    import fb_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int H_TOTAL   = 800,
    parameter int V_TOTAL   = 525,
    parameter int SCALE     = 4,
    parameter int DATA_W    = 12,
    localparam int FB_W     = fb_w(H_ACTIVE, SCALE),
    localparam int FB_H     = fb_h(V_ACTIVE, SCALE),
    localparam int ADDR_W   = fb_addr_w(H_ACTIVE, V_ACTIVE, SCALE),
    localparam int SX_W     = $clog2(H_TOTAL),
    localparam int SY_W     = $clog2(V_TOTAL),
    localparam int X_W      = $clog2(FB_W),
    localparam int Y_W      = $clog2(FB_H)
) (
    input  logic              i_clk_pxl,
    input  logic              i_reset,
    input  logic [SX_W-1:0]   i_sx,
    input  logic [SY_W-1:0]   i_sy,
    input  logic              i_hsync,
    input  logic              i_vsync,
    input  logic              i_de,
    input  logic              i_nf,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [X_W-1:0]    i_wr_x,
    input  logic [Y_W-1:0]    i_wr_y,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_swap_req,
    output logic              o_swap_done,
    output logic              o_front,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [DATA_W-1:0] o_pixel,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic              o_de
);

    localparam int SHIFT = $clog2(SCALE);
    localparam logic [SX_W-1:0] SUB_MASK = SX_W'(SCALE - 1);
    localparam logic [X_W:0] FB_W_LIM = (X_W + 1)'(FB_W);
    localparam logic [Y_W:0] FB_H_LIM = (Y_W + 1)'(FB_H);

    fb_state_e state;
    logic front;
    logic display_slot;
    logic commit;
    logic front_next;
    logic wr_accept;
    logic wr_in_range;

    logic              ag_buf;
    logic [X_W-1:0]    ag_x;
    logic [Y_W-1:0]    ag_y;
    logic [ADDR_W-1:0] ag_addr;

    logic [1:0]        rd_dly;
    logic [2:0]        de_dly;
    logic [2:0]        hs_dly;
    logic [2:0]        vs_dly;
    logic [DATA_W-1:0] pix_q;

    // The swap commits combinationally so the frame-start read already
    // fetches from the newly presented buffer.
    always_comb begin
        display_slot = i_de && ((i_sx & SUB_MASK) == '0);
        commit       = (state == SWAP_PENDING) && i_nf;
        front_next   = front ^ commit;
        o_wr_ready   = !i_reset && (state == IDLE) && !display_slot;
        wr_accept    = i_wr_valid && o_wr_ready;
        wr_in_range  = ({1'b0, i_wr_x} < FB_W_LIM) &&
                       ({1'b0, i_wr_y} < FB_H_LIM);
    end

    always_comb begin
        if (display_slot) begin
            ag_buf = front_next;
            ag_x   = X_W'(i_sx >> SHIFT);
            ag_y   = Y_W'(i_sy >> SHIFT);
        end else begin
            ag_buf = ~front;
            ag_x   = i_wr_x;
            ag_y   = i_wr_y;
        end
    end

    fb_addr_gen #(
        .FB_W   (FB_W),
        .FB_H   (FB_H),
        .ADDR_W (ADDR_W),
        .X_W    (X_W),
        .Y_W    (Y_W)
    ) u_addr_gen (
        .buf_sel (ag_buf),
        .x       (ag_x),
        .y       (ag_y),
        .addr    (ag_addr)
    );

    always_ff @(posedge i_clk_pxl) begin
        if (i_reset) begin
            state       <= IDLE;
            front       <= 1'b0;
            o_swap_done <= 1'b0;
        end else begin
            front       <= front_next;
            o_swap_done <= commit;
            case (state)
                IDLE:         if (i_swap_req) state <= SWAP_PENDING;
                SWAP_PENDING: if (i_nf) state <= IDLE;
                default:      state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk_pxl) begin
        if (i_reset) begin
            o_mem_addr  <= '0;
            o_mem_we    <= 1'b0;
            o_mem_wdata <= '0;
        end else begin
            o_mem_we <= 1'b0;
            if (display_slot) begin
                o_mem_addr <= ag_addr;
            end else if (wr_accept) begin
                o_mem_addr  <= ag_addr;
                o_mem_we    <= wr_in_range;
                o_mem_wdata <= i_wr_data;
            end
        end
    end

    // RAM data for a slot arrives two cycles later and is held for SCALE pixels.
    always_ff @(posedge i_clk_pxl) begin
        if (i_reset) begin
            rd_dly <= '0;
            de_dly <= '0;
            hs_dly <= '0;
            vs_dly <= '0;
            pix_q  <= '0;
        end else begin
            rd_dly <= {rd_dly[0], display_slot};
            de_dly <= {de_dly[1:0], i_de};
            hs_dly <= {hs_dly[1:0], i_hsync};
            vs_dly <= {vs_dly[1:0], i_vsync};
            if (rd_dly[1]) pix_q <= i_mem_rdata;
        end
    end

    assign o_front = front;
    assign o_de    = de_dly[2];
    assign o_hsync = hs_dly[2];
    assign o_vsync = vs_dly[2];
    assign o_pixel = de_dly[2] ? pix_q : '0;

endmodule

// File: tb/tb_framebuffer_scheduler.sv
// Scoreboard bench for framebuffer_scheduler: a reference model queues
// expected outputs per cycle, a negedge monitor pops and compares them.
module tb_framebuffer_scheduler;

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] d;
        bit          we;
        bit          cd;
    } ev_t;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [9:0]  i_sx;
    logic [9:0]  i_sy;
    logic        i_hsync, i_vsync, i_de, i_nf;
    logic        i_wr_valid;
    logic        o_wr_ready;
    logic [7:0]  i_wr_x;
    logic [6:0]  i_wr_y;
    logic [11:0] i_wr_data;
    logic        i_swap_req;
    logic        o_swap_done;
    logic        o_front;
    logic [15:0] o_mem_addr;
    logic        o_mem_we;
    logic [11:0] o_mem_wdata;
    logic [11:0] i_mem_rdata;
    logic [11:0] o_pixel;
    logic        o_hsync, o_vsync, o_de;

    framebuffer_scheduler dut (
        .i_clk_pxl   (clk),
        .i_reset     (i_reset),
        .i_sx        (i_sx),
        .i_sy        (i_sy),
        .i_hsync     (i_hsync),
        .i_vsync     (i_vsync),
        .i_de        (i_de),
        .i_nf        (i_nf),
        .i_wr_valid  (i_wr_valid),
        .o_wr_ready  (o_wr_ready),
        .i_wr_x      (i_wr_x),
        .i_wr_y      (i_wr_y),
        .i_wr_data   (i_wr_data),
        .i_swap_req  (i_swap_req),
        .o_swap_done (o_swap_done),
        .o_front     (o_front),
        .o_mem_addr  (o_mem_addr),
        .o_mem_we    (o_mem_we),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata),
        .o_pixel     (o_pixel),
        .o_hsync     (o_hsync),
        .o_vsync     (o_vsync),
        .o_de        (o_de)
    );

    always #5 clk = ~clk;

    logic [11:0] ram [0:65535];
    logic [11:0] ram_q = 12'h0;
    logic [11:0] exp_mem [0:65535];

    always @(posedge clk) begin
        ram_q <= ram[o_mem_addr];
        if (o_mem_we) ram[o_mem_addr] = o_mem_wdata;
    end
    assign i_mem_rdata = ram_q;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int total = 0;
    int bad = 0;
    int acc_act = 0;
    int acc_blk = 0;

    ev_t q_vid[$];
    ev_t q_mem[$];
    ev_t q_rdy[$];
    ev_t q_frt[$];
    ev_t q_swp[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h",
                     nm, cyc_n, act, req);
        end
    endtask

    function automatic ev_t mk(input int c, input int a, input int d,
                               input bit we, input bit cd);
        ev_t e;
        e.cyc = c;
        e.a   = 32'(a);
        e.d   = 32'(d);
        e.we  = we;
        e.cd  = cd;
        return e;
    endfunction

    always @(negedge clk) begin
        ev_t e;
        if (cyc_n > 0) begin
            if (q_vid.size() > 0 && q_vid[0].cyc == cyc_n) begin
                e = q_vid.pop_front();
                chk("video", 32'({o_de, o_hsync, o_vsync, o_pixel}), e.a);
            end else begin
                chk("video_idle", 32'({o_de, o_hsync, o_vsync, o_pixel}), 0);
            end
            if (q_mem.size() > 0 && q_mem[0].cyc == cyc_n) begin
                e = q_mem.pop_front();
                chk("mem_addr", 32'(o_mem_addr), e.a);
                chk("mem_we", 32'(o_mem_we), 32'(e.we));
                if (e.cd) chk("mem_wdata", 32'(o_mem_wdata), e.d);
            end else begin
                chk("mem_we_idle", 32'(o_mem_we), 0);
            end
            if (q_rdy.size() > 0 && q_rdy[0].cyc == cyc_n) begin
                e = q_rdy.pop_front();
                chk("wr_ready", 32'(o_wr_ready), e.a);
            end
            if (q_frt.size() > 0 && q_frt[0].cyc == cyc_n) begin
                e = q_frt.pop_front();
                chk("front", 32'(o_front), e.a);
            end
            if (q_swp.size() > 0 && q_swp[0].cyc == cyc_n) begin
                void'(q_swp.pop_front());
                chk("swap_done", 32'(o_swap_done), 1);
            end else begin
                chk("swap_done_idle", 32'(o_swap_done), 0);
            end
            if (!i_reset && i_wr_valid && o_wr_ready) begin
                if (i_de) acc_act++;
                else acc_blk++;
            end
        end
    end

    bit          m_front = 1'b0;
    bit          m_pend = 1'b0;
    bit          m_acc = 1'b0;
    logic [11:0] last_val = 12'h0;
    int          wx = 0;
    int          wy = 0;

    task automatic step(input int sx, input int sy, input bit wv,
                        input int x, input int y, input logic [11:0] wd,
                        input bit sw, input bit rst);
        bit de, hs, vs, nf, slot, commit, fn, rdy;
        int ra, wa;
        de = (sx < 640) && (sy < 480);
        hs = (sx >= 656) && (sx < 752);
        vs = (sy >= 490) && (sy < 492);
        nf = (sx == 0) && (sy == 0);
        slot = de && (sx % 4 == 0);
        i_sx = 10'(sx);
        i_sy = 10'(sy);
        i_de = de;
        i_hsync = hs;
        i_vsync = vs;
        i_nf = nf;
        i_reset = rst;
        i_wr_valid = wv;
        i_wr_x = 8'(x);
        i_wr_y = 7'(y);
        i_wr_data = wd;
        i_swap_req = sw;
        m_acc = 1'b0;
        if (rst) begin
            if (cyc_n > 0) q_rdy.push_back(mk(cyc_n, 0, 0, 0, 0));
            q_mem.push_back(mk(cyc_n + 1, 0, 0, 0, 1));
            q_frt.push_back(mk(cyc_n + 1, 0, 0, 0, 0));
            m_front = 1'b0;
            m_pend = 1'b0;
        end else begin
            commit = m_pend && nf;
            fn = m_front ^ commit;
            rdy = !m_pend && !slot;
            q_rdy.push_back(mk(cyc_n, int'(rdy), 0, 0, 0));
            if (slot) begin
                ra = (fn ? 19200 : 0) + (sy / 4) * 160 + sx / 4;
                last_val = exp_mem[ra];
                q_mem.push_back(mk(cyc_n + 1, ra, 0, 0, 0));
            end else if (wv && rdy) begin
                m_acc = 1'b1;
                if (x < 160 && y < 120) begin
                    wa = (m_front ? 0 : 19200) + y * 160 + x;
                    exp_mem[wa] = wd;
                    q_mem.push_back(mk(cyc_n + 1, wa, int'(wd), 1, 1));
                end
            end
            q_vid.push_back(mk(cyc_n + 3,
                int'({de, hs, vs, (de ? last_val : 12'h0)}), 0, 0, 0));
            q_frt.push_back(mk(cyc_n + 1, int'(fn), 0, 0, 0));
            if (commit) q_swp.push_back(mk(cyc_n + 1, 0, 0, 0, 0));
            m_front = fn;
            if (commit) m_pend = 1'b0;
            else if (!m_pend && sw) m_pend = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic draw(input int sx, input int sy, input bit sw);
        step(sx, sy, 1'b1, wx, wy, 12'(32'h800 + wy * 160 + wx), sw, 1'b0);
        if (m_acc) begin
            wx++;
            if (wx == 160) begin
                wx = 0;
                wy++;
            end
        end
    endtask

    task automatic quiet(input int sx, input int sy, input bit sw);
        step(sx, sy, 1'b0, 0, 0, 12'h0, sw, 1'b0);
    endtask

    initial begin
        int base_a, base_b;
        for (int i = 0; i < 65536; i++) begin
            ram[i] = 12'h0;
            exp_mem[i] = 12'h0;
        end
        for (int y = 0; y < 120; y++) begin
            for (int x = 0; x < 160; x++) begin
                ram[y * 160 + x] = 12'(x + y);
                exp_mem[y * 160 + x] = 12'(x + y);
            end
        end

        // Reset mid-frame with a writer already requesting.
        for (int i = 0; i < 5; i++) step(100 + i, 8, 1'b1, 0, 0, 12'h0, 1'b0, 1'b1);
        for (int sx = 790; sx < 800; sx++) quiet(sx, 7, 1'b0);

        // Line 8: preloaded pixels from buffer 0 while the writer streams.
        base_a = acc_act;
        base_b = acc_blk;
        for (int sx = 0; sx < 800; sx++) draw(sx, 8, 1'b0);
        chk("accepted_active", 32'(acc_act - base_a), 480);
        chk("accepted_blank", 32'(acc_blk - base_b), 160);

        // Out-of-range writes are accepted but dropped; corner write lands.
        step(650, 9, 1'b1, 160, 0, 12'h123, 1'b0, 1'b0);
        step(651, 9, 1'b1, 0, 120, 12'h456, 1'b0, 1'b0);
        step(652, 9, 1'b1, 159, 119, 12'h5a5, 1'b0, 1'b0);

        // Swap requested mid-frame, committed at the next frame start.
        for (int sx = 0; sx < 24; sx++) draw(sx, 100, sx == 5);
        for (int sx = 796; sx < 800; sx++) draw(sx, 524, 1'b0);
        for (int sx = 0; sx < 48; sx++) draw(sx, 0, 1'b0);

        // Swap request on the frame-start cycle waits a whole frame.
        quiet(799, 524, 1'b0);
        step(0, 0, 1'b1, 3, 3, 12'h777, 1'b1, 1'b0);
        for (int sx = 1; sx < 12; sx++) draw(sx, 0, sx == 3);
        quiet(799, 524, 1'b0);
        for (int sx = 0; sx < 12; sx++) quiet(sx, 0, 1'b0);

        for (int sx = 790; sx < 800; sx++) quiet(sx, 10, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("queues_drained", 32'(q_vid.size() + q_mem.size() + q_rdy.size()
            + q_frt.size() + q_swp.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
